// File: rtl/obi_ram_bridge.sv
// OBI-style data port bridge in front of the testbench RAM.
// Grants core requests after an optional stall, issues the RAM access in the
// handshake cycle, and returns in-order responses after a fixed delay.
// Addresses outside the RAM window never reach the RAM and answer with err_o.
`timescale 1ns/1ps

module obi_ram_bridge #(
  parameter int unsigned ADDR_WIDTH      = 22,
  parameter int unsigned GNT_STALL       = 0,
  parameter int unsigned RESP_DELAY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // core side
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  // RAM side
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LAST  = RESP_DELAY - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_GRANT
  } state_e;

  state_e            state_q;
  logic [3:0]        stall_cnt_q;
  logic [OUT_W-1:0]  out_cnt_q;
  logic              run_q;

  // Response tag pipeline: valid, returns-read-data, error.
  logic [LAST:0]     pv_q;
  logic [LAST:0]     pr_q;
  logic [LAST:0]     pe_q;

  logic              grant_window;
  logic              slot_free;
  logic              hs;
  logic              in_range;
  logic              resp_valid;
  logic [31:0]       resp_data;

  assign in_range   = (addr_i >> ADDR_WIDTH) == 32'd0;
  assign resp_valid = pv_q[LAST];

  // Grant qualification: window from the FSM, slot from the outstanding count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    grant_window = 1'b0;
    unique case (state_q)
      // With no stall configured, IDLE grants at once so a fresh request is granted the cycle it rises.
      S_IDLE:  grant_window = (GNT_STALL == 0);
      // The last counted stall cycle already grants, so gnt_o lands exactly GNT_STALL cycles after req_i.
      S_STALL: grant_window = (stall_cnt_q == 4'(GNT_STALL));
      S_GRANT: grant_window = 1'b1;
      default: grant_window = 1'b0;
    endcase
    // A response leaving this cycle frees a slot, so a full bridge may still grant.
    slot_free = (out_cnt_q < OUT_W'(MAX_OUTSTANDING)) || resp_valid;
    gnt_o     = run_q && req_i && grant_window && slot_free;
    hs        = gnt_o;
  end

  // RAM access is issued combinationally in the handshake cycle only.
  always_comb begin
    ram_en_o    = hs && in_range;
    ram_we_o    = hs && in_range && we_i;
    ram_addr_o  = hs ? addr_i[ADDR_WIDTH-1:0] : '0;
    ram_be_o    = hs ? be_i : 4'h0;
    ram_wdata_o = hs ? wdata_i : 32'h0;
  end

  // Keeps gnt_o low while reset is asserted, even if req_i is already high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Grant FSM with stall counter; a dropped request always returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          stall_cnt_q <= 4'd0;
          if (req_i) begin
            if (GNT_STALL == 0) begin
              state_q <= S_GRANT;
            end else begin
              // The IDLE cycle that sees req_i counts as the first stall cycle.
              state_q     <= S_STALL;
              stall_cnt_q <= 4'd1;
            end
          end
        end
        S_STALL: begin
          if (!req_i) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= 4'd0;
          end else if (stall_cnt_q == 4'(GNT_STALL)) begin
            // Granted here: restart the stall; blocked by a full bridge: wait in GRANT.
            state_q     <= hs ? S_IDLE : S_GRANT;
            stall_cnt_q <= 4'd0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 4'd1;
          end
        end
        S_GRANT: begin
          stall_cnt_q <= 4'd0;
          if (hs) begin
            state_q <= (GNT_STALL == 0) ? S_GRANT : S_IDLE;
          end else if (!req_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          stall_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Outstanding count: up on handshake, down on response, unchanged when both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
    end else begin
      unique case ({hs, resp_valid})
        2'b10:   out_cnt_q <= out_cnt_q + OUT_W'(1);
        2'b01:   out_cnt_q <= out_cnt_q - OUT_W'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // Response tag shift pipeline; reset flushes every in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pr_q <= '0;
      pe_q <= '0;
    end else begin
      pv_q[0] <= hs;
      pr_q[0] <= hs && in_range && !we_i;
      pe_q[0] <= hs && !in_range;
      for (int i = 1; i < RESP_DELAY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pr_q[i] <= pr_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  // Read data travels beside its tag. Stage 0 is the RAM output itself, which
  // is valid exactly one cycle after the handshake.
  if (RESP_DELAY == 1) begin : g_data_direct
    assign resp_data = ram_rdata_i;
  end else begin : g_data_pipe
    logic [31:0] pd_q [RESP_DELAY-1];

    // Data stages carry no reset; their contents only matter under a valid tag.
    always_ff @(posedge clk_i) begin
      // NOTE: datapath storage is deliberately left unreset; the reset tag valids already mask it.
      pd_q[0] <= ram_rdata_i;
      for (int i = 1; i < RESP_DELAY - 1; i++) begin
        pd_q[i] <= pd_q[i-1];
      end
    end

    assign resp_data = pd_q[RESP_DELAY-2];
  end

  // Response outputs are zero outside the single rvalid_o cycle.
  always_comb begin
    rvalid_o = resp_valid;
    err_o    = resp_valid && pe_q[LAST];
    rdata_o  = (resp_valid && pr_q[LAST]) ? resp_data : 32'h0;
  end

endmodule

// File: tb/tb_obi_ram_bridge.sv
// Directed bench for obi_ram_bridge: three instances with different grant
// stall / response delay settings, each fronting a small byte-enabled RAM model.
`timescale 1ns/1ps

module tb_obi_ram_bridge;

  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req       [3];
  logic          gnt       [3];
  logic [31:0]   addr      [3];
  logic          we        [3];
  logic [3:0]    be        [3];
  logic [31:0]   wdata     [3];
  logic          rvalid    [3];
  logic [31:0]   rdata     [3];
  logic          err       [3];
  logic          ram_en    [3];
  logic          ram_we    [3];
  logic [AW-1:0] ram_addr  [3];
  logic [3:0]    ram_be    [3];
  logic [31:0]   ram_wdata [3];

  int n_vec = 0;
  int n_err = 0;

  // Instance 0: no stall, delay 1. Instance 1: stall 3. Instance 2: delay 4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GS = (g == 1) ? 3 : 0;
    localparam int RD = (g == 2) ? 4 : 1;

    logic [31:0] mem [256];
    logic [31:0] rd_q;

    obi_ram_bridge #(
      .ADDR_WIDTH     (AW),
      .GNT_STALL      (GS),
      .RESP_DELAY     (RD),
      .MAX_OUTSTANDING(2)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req[g]),
      .gnt_o      (gnt[g]),
      .addr_i     (addr[g]),
      .we_i       (we[g]),
      .be_i       (be[g]),
      .wdata_i    (wdata[g]),
      .rvalid_o   (rvalid[g]),
      .rdata_o    (rdata[g]),
      .err_o      (err[g]),
      .ram_en_o   (ram_en[g]),
      .ram_addr_o (ram_addr[g]),
      .ram_we_o   (ram_we[g]),
      .ram_be_o   (ram_be[g]),
      .ram_wdata_o(ram_wdata[g]),
      .ram_rdata_i(rd_q)
    );

    // RAM model: byte-enabled write, one-cycle read latency, not reset.
    always @(posedge clk) begin
      if (ram_en[g]) begin
        if (ram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[g][b]) mem[ram_addr[g][9:2]][b*8 +: 8] <= ram_wdata[g][b*8 +: 8];
        end else begin
          rd_q <= mem[ram_addr[g][9:2]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int g, input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
    req[g] = r; addr[g] = a; we[g] = w; be[g] = b; wdata[g] = d;
  endtask

  task automatic idle(input int g);
    drive(g, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until granted (bounded); returns cycles spent waiting.
  task automatic xfer(input int g, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output int waited);
    waited = 0;
    drive(g, 1'b1, a, w, b, d);
    @(negedge clk);
    while (!gnt[g] && waited < 20) begin
      next();
      @(negedge clk);
      waited++;
    end
    check("xfer_gnt_seen", gnt[g], 1);
    next();
    idle(g);
  endtask

  initial begin
    int w;
    int idx;
    int nrv;
    int lat;
    logic found;
    logic [31:0] rd;
    logic [5:0] exp_gnt;
    logic [31:0] got [$];

    for (int g = 0; g < 3; g++) idle(g);

    // Reset state
    @(negedge clk);
    check("rst_gnt",       gnt[0], 0);
    check("rst_rvalid",    rvalid[0], 0);
    check("rst_rdata",     rdata[0], 0);
    check("rst_err",       err[0], 0);
    check("rst_ram_en",    ram_en[0], 0);
    check("rst_ram_we",    ram_we[0], 0);
    check("rst_ram_addr",  ram_addr[0], 0);
    check("rst_ram_be",    ram_be[0], 0);
    check("rst_ram_wdata", ram_wdata[0], 0);
    rst_n = 1'b1;
    next();

    // Write then read back-to-back, no stall, delay 1
    drive(0, 1'b1, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_wr_gnt",      gnt[0], 1);
    check("t1_wr_ram_en",   ram_en[0], 1);
    check("t1_wr_ram_we",   ram_we[0], 1);
    check("t1_wr_ram_addr", ram_addr[0], 32'h100);
    check("t1_wr_ram_data", ram_wdata[0], 32'hDEADBEEF);
    check("t1_wr_rvalid",   rvalid[0], 0);
    next();
    drive(0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("t1_rd_gnt",      gnt[0], 1);
    check("t1_rd_ram_en",   ram_en[0], 1);
    check("t1_rd_ram_we",   ram_we[0], 0);
    check("t1_wr_ack",      rvalid[0], 1);
    check("t1_wr_ack_data", rdata[0], 0);
    next();
    idle(0);
    @(negedge clk);
    check("t1_rd_rvalid", rvalid[0], 1);
    check("t1_rd_rdata",  rdata[0], 32'hDEADBEEF);
    check("t1_rd_err",    err[0], 0);
    next();
    @(negedge clk);
    check("t1_quiet_rvalid", rvalid[0], 0);
    check("t1_quiet_rdata",  rdata[0], 0);
    next();

    // Byte-lane write over a full word
    drive(0, 1'b1, 32'h104, 1'b1, 4'hF, 32'h11223344);
    next();
    drive(0, 1'b1, 32'h104, 1'b1, 4'b0010, 32'h0000AB00);
    next();
    drive(0, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0);
    next();
    idle(0);
    @(negedge clk);
    check("t2_rvalid", rvalid[0], 1);
    check("t2_rdata",  rdata[0], 32'h1122AB44);
    next();

    // Out-of-range read
    drive(0, 1'b1, 32'h0040_0000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("t5_gnt",    gnt[0], 1);
    check("t5_ram_en", ram_en[0], 0);
    next();
    idle(0);
    @(negedge clk);
    check("t5_rvalid", rvalid[0], 1);
    check("t5_err",    err[0], 1);
    check("t5_rdata",  rdata[0], 0);
    next();
    @(negedge clk);
    check("t5_err_clear", err[0], 0);
    next();

    // Grant stall of 3 cycles
    xfer(1, 1'b1, 32'h200, 4'hF, 32'hCAFEF00D, w);
    check("t3_wr_stall", w, 3);
    @(negedge clk);
    check("t3_wr_rvalid", rvalid[1], 1);
    check("t3_wr_err",    err[1], 0);
    next();
    xfer(1, 1'b0, 32'h200, 4'hF, 32'h0, w);
    check("t3_rd_stall", w, 3);
    @(negedge clk);
    check("t3_rd_rvalid", rvalid[1], 1);
    check("t3_rd_rdata",  rdata[1], 32'hCAFEF00D);
    next();
    @(negedge clk);
    check("t3_quiet", rvalid[1], 0);
    next();

    // Outstanding limit with delay 4: preload, drain, then held-req reads
    for (int i = 0; i < 4; i++) xfer(2, 1'b1, 32'(i * 4), 4'hF, 32'hA000_0000 | 32'(i), w);
    repeat (10) next();
    exp_gnt = 6'b110011;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) drive(2, 1'b1, 32'(idx * 4), 1'b0, 4'hF, 32'h0);
      else         idle(2);
      @(negedge clk);
      if (c < 6) check($sformatf("t4_gnt_c%0d", c), gnt[2], exp_gnt[c]);
      if (c == 4) check("t4_rvalid_c4", rvalid[2], 1);
      if (rvalid[2]) got.push_back(rdata[2]);
      if (gnt[2]) idx++;
      next();
    end
    idle(2);
    check("t4_nresp", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("t4_rdata%0d", i), got[i], 32'hA000_0000 | 32'(i));

    // Reset with two reads outstanding
    drive(2, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("t6_gnt0", gnt[2], 1);
    next();
    drive(2, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("t6_gnt1", gnt[2], 1);
    next();
    idle(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt",    gnt[2], 0);
    check("t6_rst_rvalid", rvalid[2], 0);
    check("t6_rst_rdata",  rdata[2], 0);
    check("t6_rst_err",    err[2], 0);
    check("t6_rst_ram_en", ram_en[2], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid[2]) nrv++;
    end
    check("t6_no_rvalid", nrv, 0);
    next();
    xfer(2, 1'b0, 32'h8, 4'hF, 32'h0, w);
    check("t6_next_wait", w, 0);
    found = 1'b0;
    lat = 0;
    rd = 32'h0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clk);
      if (rvalid[2]) begin
        found = 1'b1;
        lat = k;
        rd = rdata[2];
      end else begin
        next();
      end
    end
    check("t6_next_seen",  found, 1);
    check("t6_next_lat",   lat, 4);
    check("t6_next_rdata", rd, 32'hA000_0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
